rs_key_schedule: RTL and testbench

RS_KEY_SCHEDULE -- requirements
Module: rs_key_schedule

---
 rtl/rs_key_schedule.sv | 130 +++++++++++++
 tb/tb_rs_key_schedule.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/rs_key_schedule.sv
// ============================================================================
//  Module      : rs_key_schedule
//  Description : Iterative Twofish Reed-Solomon key schedule. Folds one key
//                byte per clock into four GF(2^8) multiply-accumulates to
//                produce the two 32-bit S words that key the S-boxes.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rs_key_schedule (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key_in,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic [31:0]  s0_word,
    output logic [31:0]  s1_word,
    output logic         s_valid
);

    // FSM encoding
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    // RS matrix rows; column c sits in byte c (little-endian within each row)
    localparam logic [63:0] RS_ROW0 = 64'h9EDB585A8755A401;
    localparam logic [63:0] RS_ROW1 = 64'hE568C61EF38256A4;
    localparam logic [63:0] RS_ROW2 = 64'h193DAE47C1FCA102;
    localparam logic [63:0] RS_ROW3 = 64'h039EDB585A8755A4;
    localparam logic [3:0][63:0] RS_MATRIX = {RS_ROW3, RS_ROW2, RS_ROW1, RS_ROW0};

    // Reduction constant: x^8 = x^6 + x^3 + x^2 + 1 (low byte of 0x14D)
    localparam logic [7:0] GF_POLY = 8'h4D;

    logic [1:0]   state;
    logic [127:0] key_reg;
    logic [3:0]   cnt;
    logic [31:0]  acc;
    logic [31:0]  s0_hold;
    logic [31:0]  s1_hold;

    logic [7:0]   cur_byte;
    logic [31:0]  products;
    logic [31:0]  acc_next;

    // Shift-and-add GF(2^8) multiply modulo 0x14D
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY) : {x[6:0], 1'b0};
        end
        return p;
    endfunction

    // Byte under the counter comes only from the latched key, never key_in
    assign cur_byte = key_reg[{cnt, 3'b000} +: 8];

    // One multiplier per RS row; the coefficient column is cnt modulo 8 since
    // both S words reuse the same matrix over their own eight key bytes
    generate
        for (genvar j = 0; j < 4; j++) begin : g_row
            assign products[8*j +: 8] =
                gf_mul(RS_MATRIX[j][{cnt[2:0], 3'b000} +: 8], cur_byte);
        end
    endgenerate

    assign acc_next = acc ^ products;
    assign busy     = (state != IDLE);

    // Control FSM, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            key_reg <= '0;
            cnt     <= '0;
            acc     <= '0;
            s0_hold <= '0;
            s1_hold <= '0;
            s0_word <= '0;
            s1_word <= '0;
            s_valid <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        key_reg <= key_in;
                        cnt     <= '0;
                        acc     <= '0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == 4'd7) begin
                        s0_hold <= acc_next;
                        acc     <= '0;
                    end else if (cnt == 4'd15) begin
                        s1_hold <= acc_next;
                        acc     <= acc_next;
                        state   <= FINISH;
                    end else begin
                        acc <= acc_next;
                    end
                end
                FINISH: begin
                    // Both words publish together so no partial result is seen
                    s0_word <= s0_hold;
                    s1_word <= s1_hold;
                    s_valid <= 1'b1;
                    done    <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rs_key_schedule.sv
// ============================================================================
//  Module      : tb_rs_key_schedule
//  Description : Directed self-checking bench for rs_key_schedule.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rs_key_schedule;

    logic         clk;
    logic         rst_n;
    logic [127:0] key_in;
    logic         start;
    logic         busy;
    logic         done;
    logic [31:0]  s0_word;
    logic [31:0]  s1_word;
    logic         s_valid;

    int vectors;
    int miscompares;

    rs_key_schedule dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_in  (key_in),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .s0_word (s0_word),
        .s1_word (s1_word),
        .s_valid (s_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Key with byte k set to v, all other bytes zero
    function automatic logic [127:0] one_byte(input int k, input logic [7:0] v);
        logic [127:0] r;
        r = '0;
        r[8*k +: 8] = v;
        return r;
    endfunction

    // Pulse start for one cycle and wait for done, checking latency and result
    task automatic do_run(input string tag, input logic [127:0] k,
                          input logic [31:0] e0, input logic [31:0] e1);
        int n;
        logic got;
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        key_in = k;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        key_in = '0;
        while (n < 40 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (done) got = 1'b1;
        end
        chk({tag, "_latency"}, n, 17);
        chk({tag, "_s0"}, s0_word, e0);
        chk({tag, "_s1"}, s1_word, e1);
        chk({tag, "_valid"}, {31'd0, s_valid}, 32'd1);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int busy_cnt;
        int done_cnt;
        int done_at;
        int d0;
        int d1;
        int d2;
        int unstable;

        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        start       = 1'b0;
        key_in      = '0;

        // Reset state, checked before any clock edge
        #3;
        chk("rst_s0", s0_word, 32'h0);
        chk("rst_s1", s1_word, 32'h0);
        chk("rst_flags", {29'd0, busy, done, s_valid}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero key, single bytes, last byte of each half
        do_run("zero",  128'h0,                 32'h00000000, 32'h00000000);
        do_run("m0_01", one_byte(0, 8'h01),     32'hA402A401, 32'h00000000);
        do_run("m0_02", one_byte(0, 8'h02),     32'h05040502, 32'h00000000);
        do_run("m1_01", one_byte(1, 8'h01),     32'h55A156A4, 32'h00000000);
        do_run("m7_01", one_byte(7, 8'h01),     32'h0319E59E, 32'h00000000);
        do_run("m8_01", one_byte(8, 8'h01),     32'h00000000, 32'hA402A401);
        do_run("m15_01", one_byte(15, 8'h01),   32'h00000000, 32'h0319E59E);
        do_run("m0m1",  one_byte(0, 8'h01) | one_byte(1, 8'h01),
               32'hF1A3F2A5, 32'h00000000);

        // Busy protection: restart attempts with a new key mid-run
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = 0;
        @(negedge clk);
        key_in = one_byte(0, 8'h01);
        start  = 1'b1;
        @(negedge clk);
        if (busy) busy_cnt++;
        start  = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_at = i;
            end
            if (i == 3) begin
                start  = 1'b1;
                key_in = one_byte(1, 8'h01);
            end
            if (i == 8) start = 1'b0;
        end
        chk("busyprot_done_count", done_cnt, 1);
        chk("busyprot_done_at", done_at, 17);
        chk("busyprot_busy_cycles", busy_cnt, 17);
        chk("busyprot_s0", s0_word, 32'hA402A401);

        // Mid-run reset at cnt=9
        @(negedge clk);
        key_in = one_byte(0, 8'h02);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        for (int i = 1; i <= 9; i++) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_s0", s0_word, 32'h0);
        chk("midrst_s1", s1_word, 32'h0);
        chk("midrst_flags", {29'd0, busy, done, s_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        done_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("midrst_no_done", done_cnt, 0);
        do_run("after_rst", one_byte(0, 8'h01), 32'hA402A401, 32'h00000000);

        // Back-to-back with start held high
        d0 = 0;
        d1 = 0;
        d2 = 0;
        done_cnt = 0;
        unstable = 0;
        @(negedge clk);
        key_in = one_byte(0, 8'h02);
        start  = 1'b1;
        @(negedge clk);
        for (n = 1; n <= 56; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (done_cnt == 0) d0 = n;
                else if (done_cnt == 1) d1 = n;
                else if (done_cnt == 2) d2 = n;
                done_cnt++;
            end
            if (done_cnt > 0 && s0_word !== 32'h05040502) unstable++;
        end
        start = 1'b0;
        chk("b2b_first", d0, 17);
        chk("b2b_second", d1, 35);
        chk("b2b_third", d2, 53);
        chk("b2b_stable", unstable, 0);
        for (int i = 0; i < 20; i++) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
